// File: rtl/iterative_divider.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle on operand
// magnitudes, with two's-complement sign fix-up applied in the FINISH cycle.
module iterative_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             zero_flag
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v,
                                                 input logic             sgn_en);
        return (sgn_en && v[WIDTH-1]) ? neg2c(v) : v;
    endfunction

    // Control and output state
    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q,  div_zero_d;
    logic             zero_flag_q, zero_flag_d;

    // Datapath state (no reset needed; always loaded on accept)
    logic [WIDTH-1:0] dsr_q,       dsr_d;
    logic [WIDTH-1:0] quo_q,       quo_d;
    logic [WIDTH-1:0] rem_q,       rem_d;
    logic [WIDTH-1:0] raw_dvd_q,   raw_dvd_d;
    logic             neg_quo_q,   neg_quo_d;
    logic             neg_rem_q,   neg_rem_d;
    logic             dz_q,        dz_d;

    logic [WIDTH:0]          shifted;
    logic signed [WIDTH:0]   trial;
    logic [WIDTH-1:0]        q_fin;
    logic [WIDTH-1:0]        r_fin;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        zero_flag_d = zero_flag_q;
        dsr_d       = dsr_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        raw_dvd_d   = raw_dvd_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dz_d        = dz_q;

        // The remainder never exceeds the divisor, so a 32-bit store plus the
        // incoming dividend bit is enough to form the 33-bit partial remainder.
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = $signed(shifted) - $signed({1'b0, dsr_q});

        q_fin = neg_quo_q ? neg2c(quo_q) : quo_q;
        r_fin = neg_rem_q ? neg2c(rem_q) : rem_q;
        if (dz_q) begin
            q_fin = '1;
            r_fin = raw_dvd_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dsr_d     = abs_mag(divisor, is_signed);
                    quo_d     = abs_mag(dividend, is_signed);
                    rem_d     = '0;
                    raw_dvd_d = dividend;
                    neg_quo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = is_signed & dividend[WIDTH-1];
                    dz_d      = (divisor == '0);
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = S_CALC;
                end
            end

            S_CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FINISH;
                end
            end

            S_FINISH: begin
                quotient_d  = q_fin;
                remainder_d = r_fin;
                div_zero_d  = dz_q;
                zero_flag_d = (q_fin == '0);
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            zero_flag_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            zero_flag_q <= zero_flag_d;
        end
    end

    always_ff @(posedge clk) begin
        dsr_q     <= dsr_d;
        quo_q     <= quo_d;
        rem_q     <= rem_d;
        raw_dvd_q <= raw_dvd_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
        dz_q      <= dz_d;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign zero_flag = zero_flag_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: expected results are queued on issue
// and compared against the DUT when done pulses.
module tb_iterative_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;
    logic        zero_flag;

    always #5 clk = ~clk;

    iterative_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .zero_flag (zero_flag)
    );

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        zf;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        if (b == 32'd0) begin
            e.q  = 32'hFFFFFFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else if (s) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                e.q = 32'h80000000;
                e.r = 32'd0;
            end else begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end
            e.dz = 1'b0;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        e.zf = (e.q == 32'd0);
        return e;
    endfunction

    // Caller is positioned #1 after a rising edge; start is sampled at the next edge (E0).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input bit inject);
        int   cyc;
        bit   busy_ok;
        exp_t e;
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        sb.push_back(model(a, b, s));
        @(posedge clk); #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = ~s;
        check("busy_after_E0", {31'd0, busy}, 32'd1);
        cyc     = 0;
        busy_ok = 1'b1;
        while (!done && cyc < 40) begin
            if (inject && cyc == 4) begin
                start     = 1'b1;
                dividend  = 32'd999;
                divisor   = 32'd3;
                is_signed = 1'b0;
            end
            if (inject && cyc == 5) start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, 32'd33);
        check("busy_during_op", {31'd0, busy_ok}, 32'd1);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            last_exp = e;
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
            check("zero_flag", {31'd0, zero_flag}, {31'd0, e.zf});
        end else begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_quotient"}, quotient, 32'd0);
        check({tag, "_remainder"}, remainder, 32'd0);
        check({tag, "_div_zero"}, {31'd0, div_zero}, 32'd0);
        check({tag, "_zero_flag"}, {31'd0, zero_flag}, 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          saw_done;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(32'd100, 32'd7, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("hold_quotient", quotient, last_exp.q);
        check("hold_remainder", remainder, last_exp.r);

        run_op(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
        run_op(32'd7, 32'hFFFFFFFE, 1'b1, 1'b0);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(32'h12345678, 32'd0, 1'b1, 1'b0);
        run_op(32'h12345678, 32'd0, 1'b0, 1'b0);

        run_op(32'd1000, 32'd10, 1'b0, 1'b1);
        run_op(32'd5, 32'd3, 1'b0, 1'b0);

        // Abort mid-CALC: rst sampled at E10
        start     = 1'b1;
        dividend  = 32'd500;
        divisor   = 32'd9;
        is_signed = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("abort");
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);

        run_op(32'd100, 32'd7, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i < 4) ? ($urandom & 32'h0000FFFF) : $urandom;
            run_op(ra, rb, 1'(i & 1), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iterative_divider.md
# iterative_divider

Multi-cycle 32-bit integer divider that sits beside the single-cycle arithmetic unit in the execute stage. It handles the DIV/DIVU class of operations that the combinational ALU cannot complete in one cycle. The pipeline control issues a one-cycle start, stalls on busy, and captures quotient/remainder on a one-cycle done pulse. Implementation is a radix-2 restoring divider on magnitudes, with sign fix-up on completion.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported and verified
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- is_signed  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- dividend  in  32  op_a-side operand; sampled with start
- divisor  in  32  op_b-side operand; sampled with start
- busy  out  1  high from the accepting edge until the done edge
- done  out  1  one-cycle completion pulse
- quotient  out  32  registered quotient; held until next done
- remainder  out  32  registered remainder; held until next done
- div_zero  out  1  divisor was 0 for the completed operation; held with results
- zero_flag  out  1  quotient == 0; held with results

## Operation
- States: IDLE, CALC, FINISH.
- IDLE + start=1:
  - latch |dividend| and |divisor| (magnitudes only when is_signed=1)
  - latch sign_q = sign(dividend) ^ sign(divisor), sign_r = sign(dividend), is_signed, divisor==0, raw dividend
  - clear the 33-bit partial remainder; set the 5-bit count to 0; go to CALC.
- CALC, one bit per cycle, MSB first:
  - shift the partial remainder left, bringing in the next dividend bit
  - trial = partial − |divisor| (33-bit)
  - if trial is non-negative, keep trial and set the quotient bit to 1; else restore and set 0
  - after count 31, go to FINISH.
- FINISH:
  - if signed, quotient = sign_q ? −q : q and remainder = sign_r ? −r : r (32-bit two's complement)
  - register the outputs; done=1 for this one cycle; go to IDLE.
- Divide by zero: latency is unchanged. Results are forced to quotient=32'hFFFFFFFF, remainder = raw dividend, div_zero=1.
- Signed overflow (32'h80000000 / 32'hFFFFFFFF) needs no special case. The natural result is quotient=32'h80000000, remainder=0, div_zero=0.
- start while busy is ignored. Operands are not re-sampled and no error is flagged.
- start in the IDLE cycle right after done is accepted, so operations can run back-to-back.
- Operand inputs may change freely after the accepting edge.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_zero=0, zero_flag=1; state IDLE.
- Accepting edge E0: busy reads 1 after E0.
- E1..E32 are the iteration edges. E33 is the FINISH edge.
- After E33: done=1 and results are valid for one cycle; busy=0 in the same cycle.
- Fixed latency: done is asserted 33 cycles after the accepting edge, for all operands including divisor 0.
- rst=1 at any edge, including mid-CALC or during FINISH, aborts the operation. All outputs and state return to reset values at that edge; no done is produced for the aborted request.
- rst has priority over start in the same cycle.
- Outputs change only at a FINISH edge or at reset.

## Test plan
- Unsigned 100 / 7, start at E0 -> busy high for 33 cycles; done at E33; quotient=14, remainder=2, zero_flag=0, div_zero=0.
- Signed −7 / 2 (32'hFFFFFFF9 / 2) -> quotient=32'hFFFFFFFD, remainder=32'hFFFFFFFF. Signed 7 / −2 -> quotient=32'hFFFFFFFD, remainder=1.
- 32'h80000000 / 32'hFFFFFFFF: signed -> quotient=32'h80000000, remainder=0. Unsigned -> quotient=0, remainder=32'h80000000, zero_flag=1.
- Divisor 0, dividend 32'h12345678, signed and unsigned -> done at E33; quotient=32'hFFFFFFFF, remainder=32'h12345678, div_zero=1.
- Second start at E5 with different operands -> ignored, first result unchanged. Start in the cycle after done -> accepted, second done 33 cycles later.
- rst asserted at E10 -> busy=0, no done pulse, outputs zero with zero_flag=1. Next start completes normally.
